// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//   Bit-serial unsigned subtractor: diff = (a - b - b_in) mod 2**WIDTH,
//   one bit per clock, LSB first. It is the multi-cycle, small-area
//   counterpart of the parallel full adder, with borrow in place of carry.
//   Operands are captured on an accepted start; a single done pulse marks
//   the point where diff/b_out hold the new result.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, sampled only while idle
//   a      in   WIDTH  minuend, captured with start
//   b      in   WIDTH  subtrahend, captured with start
//   b_in   in   1      borrow-in, captured with start
//   busy   out  1      high while bits are being shifted
//   done   out  1      one-cycle pulse, diff/b_out valid
//   diff   out  WIDTH  (a - b - b_in) mod 2**WIDTH, held between operations
//   b_out  out  1      final borrow, 1 iff a < b + b_in
// -----------------------------------------------------------------------------

// One-bit full subtractor slice: the combinational core used every SHIFT cycle.
module serial_sub_fs (
    input  logic a,
    input  logic b,
    input  logic br_in,
    output logic d,
    output logic br_out
);
    assign d      = a ^ b ^ br_in;
    assign br_out = (~a & b) | (~(a ^ b) & br_in);
endmodule

module serial_sub #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             b_out
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Captured operand pair; both halves shift right together so bit 0 is
    // always the bit being processed.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } opnd_t;

    state_t           state;
    opnd_t            opnd;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] res;

    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] res_nxt;

    serial_sub_fs u_fs (
        .a      (opnd.a[0]),
        .b      (opnd.b[0]),
        .br_in  (br),
        .d      (d_bit),
        .br_out (br_nxt)
    );

    // New bit enters at the MSB; after WIDTH shifts bit 0 sits in res[0].
    assign res_nxt = {d_bit, res[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opnd  <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            res   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            diff  <= '0;
            b_out <= 1'b0;
        end else begin
            // done is registered from the DONE state, so the pulse appears
            // the cycle after the result lands and while the FSM is back in
            // IDLE; it can never overlap busy.
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        opnd.a <= a;
                        opnd.b <= b;
                        br     <= b_in;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    opnd.a <= opnd.a >> 1;
                    opnd.b <= opnd.b >> 1;
                    br     <= br_nxt;
                    res    <= res_nxt;
                    if (cnt == LAST) begin
                        // Outputs only move on the final bit, so they hold
                        // the previous result for the whole operation.
                        diff  <= res_nxt;
                        b_out <= br_nxt;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
module tb_serial_sub;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         b_out;

    int n_chk  = 0;
    int n_fail = 0;

    // Model of the held outputs (value before the current operation).
    logic [W-1:0] m_diff;
    logic         m_bout;

    serial_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .b_in  (b_in),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .b_out (b_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer subtraction, low W+1 bits give {borrow,diff}.
    function automatic logic [W:0] ref_sub(input int av, input int bv, input int bi);
        int r;
        r = av - bv - bi;
        return r[W:0];
    endfunction

    task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        @(negedge clk);
        a     = av;
        b     = bv;
        b_in  = bi;
        start = 1'b1;
    endtask

    // Follows one operation from edge k0 (edge 0 = start accepted) through
    // the done pulse, checking every cycle. junk: fire start with new
    // operands while busy. hold: leave start high throughout.
    task automatic track(input int k0, input logic junk, input logic hold,
                         input logic [W:0] exp);
        int ndone = 0;
        for (int k = k0; k <= W + 1; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 && !hold) begin
                start = junk;
                if (junk) begin
                    a    = '1;
                    b    = W'(1);
                    b_in = 1'($urandom);
                end else begin
                    a    = W'($urandom);
                    b    = W'($urandom);
                    b_in = 1'($urandom);
                end
            end
            if (k == W && junk) start = 1'b0;
            if (done) ndone++;
            chk("busy", 32'(busy), 32'(k < W));
            chk("done", 32'(done), 32'(k == W + 1));
            chk("diff", 32'(diff), 32'((k < W) ? m_diff : exp[W-1:0]));
            chk("b_out", 32'(b_out), 32'((k < W) ? m_bout : exp[W]));
        end
        m_diff = exp[W-1:0];
        m_bout = exp[W];
        @(posedge clk);
        #1;
        chk("done_low", 32'(done), 32'(0));
        chk("restart", 32'(busy), 32'(hold));
        if (k0 == 0) chk("one_done", 32'(ndone), 32'(1));
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                      input logic junk);
        launch(av, bv, bi);
        track(0, junk, 1'b0, ref_sub(int'(av), int'(bv), int'(bi)));
    endtask

    initial begin
        logic [W:0] e;
        rst_n = 1'b0;
        start = 1'b1;
        a     = W'(9);
        b     = W'(3);
        b_in  = 1'b0;
        m_diff = '0;
        m_bout = 1'b0;

        // Reset held with start high: nothing moves.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_done", 32'(done), 32'(0));
            chk("rst_diff", 32'(diff), 32'(0));
            chk("rst_bout", 32'(b_out), 32'(0));
        end
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;

        // Directed cases.
        op(4'h9, 4'h3, 1'b0, 1'b0);
        chk("9-3", 32'({b_out, diff}), 32'(5'h06));
        op(4'h3, 4'h9, 1'b0, 1'b0);
        chk("3-9", 32'({b_out, diff}), 32'(5'h1A));
        op(4'h0, 4'h0, 1'b1, 1'b0);
        chk("0-0-1", 32'({b_out, diff}), 32'(5'h1F));
        op(4'h5, 4'h5, 1'b0, 1'b0);
        chk("5-5", 32'({b_out, diff}), 32'(5'h00));

        // start with a=F, b=1 while busy is ignored.
        op(4'h9, 4'h3, 1'b0, 1'b1);
        chk("junk_ign", 32'({b_out, diff}), 32'(5'h06));

        // start held high through DONE: second op only begins from IDLE.
        launch(4'h3, 4'h9, 1'b0);
        e = ref_sub(3, 9, 0);
        track(0, 1'b0, 1'b1, e);
        start = 1'b0;
        track(1, 1'b0, 1'b0, e);

        // Reset in the middle of SHIFT.
        launch(4'hE, 4'h1, 1'b0);
        for (int k = 0; k <= 2; k++) @(posedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'(0));
        chk("mid_done", 32'(done), 32'(0));
        chk("mid_diff", 32'(diff), 32'(0));
        chk("mid_bout", 32'(b_out), 32'(0));
        m_diff = '0;
        m_bout = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int nd = 0;
            for (int k = 0; k < 8; k++) begin
                @(posedge clk);
                #1;
                if (done || busy) nd++;
            end
            chk("no_done_after_rst", 32'(nd), 32'(0));
        end
        op(4'h7, 4'h2, 1'b0, 1'b0);
        chk("7-2", 32'({b_out, diff}), 32'(5'h05));

        // Exhaustive over {a, b, b_in}.
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    op(W'(ai), W'(bi), 1'(ci), 1'b0);

        // Random operations, some with junk starts during SHIFT.
        for (int i = 0; i < 40; i++)
            op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global time bound so a stuck design still ends with a summary.
    initial begin
        #2000000;
        n_fail++;
        $display("FAIL timeout: observed no end of test, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
